// File: rtl/rx50_pkg.sv
// Shared definitions for the 50 MHz serial receive front end and its
// downstream FIFO write controller.
package rx50_pkg;

    // Receive framing FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_OVERRUN = 2'd2
    } rx_state_t;

    // Default packet header values.
    localparam logic [7:0] HDR_A = 8'hA5;
    localparam logic [7:0] HDR_B = 8'hC3;

    // Data bytes following a header; also used by the FIFO write controller.
    localparam int PAYLOAD_BYTES = 4;

    // True when a byte matches either header value.
    function automatic logic is_header(input logic [7:0] b,
                                       input logic [7:0] hdr_a,
                                       input logic [7:0] hdr_b);
        return (b == hdr_a) || (b == hdr_b);
    endfunction

endpackage

// File: rtl/shift_reg_50.sv
// Serial receive front end: assembles MSB-first bytes framed by data_ena,
// flags packet headers outside a payload, and reports framing errors.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | between frames, waiting for data_ena
//   ST_SHIFT   | collecting bits of a frame
//   ST_OVERRUN | 9th bit seen; ignoring bits until data_ena drops
module shift_reg_50 #(
    parameter logic [7:0] HDR_A         = rx50_pkg::HDR_A,
    parameter logic [7:0] HDR_B         = rx50_pkg::HDR_B,
    parameter int         PAYLOAD_BYTES = rx50_pkg::PAYLOAD_BYTES
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       serial_data,
    input  logic       data_ena,
    output logic [7:0] parallel_data,
    output logic       a5_or_c3,
    output logic       byte_done,
    output logic       frame_err,
    output logic       in_packet
);
    import rx50_pkg::*;

    localparam int PW = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [PW-1:0] PAY_LAST = PW'(PAYLOAD_BYTES);

    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    // The 3-bit bit counter wraps 7 -> 0 on the 8th bit, so a value of 0
    // while in ST_SHIFT means a full byte has been collected.
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_par;
    logic [PW-1:0] r_pay_cnt;
    logic          r_hdr;
    logic          r_byte_done;
    logic          r_frame_err;
    logic          r_in_pkt;

    logic          w_shift_en;
    logic          w_first_bit;
    logic          w_byte_ok;
    logic          w_frame_err;
    logic          w_full;

    assign w_full = (r_bit_cnt == 3'd0);

    // FSM state register.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_first_bit = 1'b0;
        w_byte_ok   = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (data_ena) begin
                    w_shift_en  = 1'b1;
                    w_first_bit = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (data_ena) begin
                    if (w_full) begin
                        w_frame_err = 1'b1;
                        w_state_nxt = ST_OVERRUN;
                    end else begin
                        w_shift_en = 1'b1;
                    end
                end else begin
                    if (w_full) begin
                        w_byte_ok = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OVERRUN: begin
                if (!data_ena) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register and bit counter; a reset discards any partial byte.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else if (w_shift_en) begin
            r_shift   <= {r_shift[6:0], serial_data};
            r_bit_cnt <= w_first_bit ? 3'd1 : r_bit_cnt + 3'd1;
        end
    end

    // Registered byte output and one-cycle framing pulses.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            r_par       <= 8'h00;
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_done <= w_byte_ok;
            r_frame_err <= w_frame_err;
            if (w_byte_ok) begin
                r_par <= r_shift;
            end
        end
    end

    // Header detection and payload tracking; a framing error abandons the packet.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            r_hdr     <= 1'b0;
            r_in_pkt  <= 1'b0;
            r_pay_cnt <= '0;
        end else begin
            r_hdr <= 1'b0;
            if (w_frame_err) begin
                r_in_pkt <= 1'b0;
            end else if (w_byte_ok) begin
                if (!r_in_pkt) begin
                    if (is_header(r_shift, HDR_A, HDR_B)) begin
                        r_hdr     <= 1'b1;
                        r_in_pkt  <= 1'b1;
                        r_pay_cnt <= '0;
                    end
                end else begin
                    r_pay_cnt <= r_pay_cnt + PW'(1);
                    if (r_pay_cnt + PW'(1) == PAY_LAST) begin
                        r_in_pkt <= 1'b0;
                    end
                end
            end
        end
    end

    assign parallel_data = r_par;
    assign a5_or_c3      = r_hdr;
    assign byte_done     = r_byte_done;
    assign frame_err     = r_frame_err;
    assign in_packet     = r_in_pkt;

endmodule

// File: tb/tb_shift_reg_50.sv
// Directed bench for shift_reg_50: inputs change and outputs are checked on
// the falling edge, so each check sees the result of the preceding rising edge.
module tb_shift_reg_50;

    logic       clk_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_data = 1'b0;
    logic       data_ena = 1'b0;
    logic [7:0] parallel_data;
    logic       a5_or_c3;
    logic       byte_done;
    logic       frame_err;
    logic       in_packet;

    int n_cmp = 0;
    int n_err = 0;
    int hdr_cnt = 0;
    int done_cnt = 0;
    int hdr_base;
    int done_base;

    shift_reg_50 dut (
        .clk_50        (clk_50),
        .reset_n       (reset_n),
        .serial_data   (serial_data),
        .data_ena      (data_ena),
        .parallel_data (parallel_data),
        .a5_or_c3      (a5_or_c3),
        .byte_done     (byte_done),
        .frame_err     (frame_err),
        .in_packet     (in_packet)
    );

    always #10 clk_50 = ~clk_50;

    // Pulse tallies, sampled shortly after each rising edge.
    always @(posedge clk_50) begin
        #1;
        if (a5_or_c3 === 1'b1) hdr_cnt++;
        if (byte_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_50);
    endtask

    // Sends 8 bits MSB first, then drops data_ena; returns just after edge E.
    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            data_ena    = 1'b1;
            serial_data = b[i];
            cyc();
        end
        data_ena    = 1'b0;
        serial_data = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        cyc();
        cyc();
        check("rst_pd",   parallel_data, 8'h00);
        check("rst_hdr",  a5_or_c3,  8'h00);
        check("rst_done", byte_done, 8'h00);
        check("rst_ferr", frame_err, 8'h00);
        check("rst_inpk", in_packet, 8'h00);
        reset_n = 1'b1;
        cyc();

        // Header 0xA5
        send_byte(8'hA5);
        check("a5_pd",   parallel_data, 8'hA5);
        check("a5_done", byte_done, 8'h01);
        check("a5_hdr",  a5_or_c3,  8'h01);
        check("a5_inpk", in_packet, 8'h01);
        cyc();
        check("a5_done_1cyc", byte_done, 8'h00);
        check("a5_hdr_1cyc",  a5_or_c3,  8'h00);
        check("a5_inpk_hold", in_packet, 8'h01);
        check("a5_pd_hold",   parallel_data, 8'hA5);

        // Reset mid-packet clears the packet
        reset_n = 1'b0;
        cyc();
        check("rst_pkt_inpk", in_packet, 8'h00);
        check("rst_pkt_pd",   parallel_data, 8'h00);
        reset_n = 1'b1;
        cyc();

        // Full packet C3 12 A5 34 56
        hdr_base  = hdr_cnt;
        done_base = done_cnt;
        send_byte(8'hC3);
        check("pk_c3_hdr",  a5_or_c3, 8'h01);
        check("pk_c3_inpk", in_packet, 8'h01);
        send_byte(8'h12);
        check("pk_12_pd",   parallel_data, 8'h12);
        check("pk_12_hdr",  a5_or_c3, 8'h00);
        check("pk_12_inpk", in_packet, 8'h01);
        send_byte(8'hA5);
        check("pk_a5_pd",   parallel_data, 8'hA5);
        check("pk_a5_hdr",  a5_or_c3, 8'h00);
        check("pk_a5_inpk", in_packet, 8'h01);
        send_byte(8'h34);
        check("pk_34_inpk", in_packet, 8'h01);
        send_byte(8'h56);
        check("pk_56_pd",   parallel_data, 8'h56);
        check("pk_56_done", byte_done, 8'h01);
        check("pk_56_inpk", in_packet, 8'h00);
        cyc();
        check("pk_hdr_cnt",  8'(hdr_cnt - hdr_base),   8'd1);
        check("pk_done_cnt", 8'(done_cnt - done_base), 8'd5);

        // Stray byte outside a packet
        send_byte(8'h7E);
        check("st_pd",   parallel_data, 8'h7E);
        check("st_done", byte_done, 8'h01);
        check("st_hdr",  a5_or_c3,  8'h00);
        check("st_inpk", in_packet, 8'h00);
        cyc();

        // Short frame: 5 bits
        done_base = done_cnt;
        for (int i = 0; i < 5; i++) begin
            data_ena    = 1'b1;
            serial_data = 1'b1;
            cyc();
            check("sh_noferr_bits", frame_err, 8'h00);
        end
        data_ena = 1'b0;
        cyc();
        check("sh_ferr", frame_err, 8'h01);
        check("sh_done", byte_done, 8'h00);
        check("sh_pd",   parallel_data, 8'h7E);
        cyc();
        check("sh_ferr_1cyc", frame_err, 8'h00);
        check("sh_no_done", 8'(done_cnt - done_base), 8'd0);

        // Long frame mid-packet: header, one payload byte, then 11 bits
        send_byte(8'hC3);
        check("lg_c3_hdr", a5_or_c3, 8'h01);
        send_byte(8'h12);
        check("lg_12_inpk", in_packet, 8'h01);
        done_base = done_cnt;
        for (int i = 0; i < 11; i++) begin
            data_ena    = 1'b1;
            serial_data = i[0];
            cyc();
            if (i == 7) check("lg_ferr_8th", frame_err, 8'h00);
            if (i == 8) begin
                check("lg_ferr_9th", frame_err, 8'h01);
                check("lg_inpk_9th", in_packet, 8'h00);
            end
            if (i == 9) check("lg_ferr_once", frame_err, 8'h00);
        end
        data_ena = 1'b0;
        cyc();
        check("lg_drop_ferr", frame_err, 8'h00);
        check("lg_drop_done", byte_done, 8'h00);
        check("lg_drop_pd",   parallel_data, 8'h12);
        check("lg_no_done", 8'(done_cnt - done_base), 8'd0);
        send_byte(8'hC3);
        check("lg_c3_again_hdr",  a5_or_c3, 8'h01);
        check("lg_c3_again_inpk", in_packet, 8'h01);
        cyc();

        // Reset mid-byte: 4 bits then reset with data_ena still high
        for (int i = 0; i < 4; i++) begin
            data_ena    = 1'b1;
            serial_data = 1'b1;
            cyc();
        end
        reset_n = 1'b0;
        cyc();
        check("rmb_pd",   parallel_data, 8'h00);
        check("rmb_hdr",  a5_or_c3,  8'h00);
        check("rmb_done", byte_done, 8'h00);
        check("rmb_ferr", frame_err, 8'h00);
        check("rmb_inpk", in_packet, 8'h00);
        reset_n  = 1'b1;
        data_ena = 1'b0;
        cyc();
        check("rmb_idle_ferr", frame_err, 8'h00);
        send_byte(8'hA5);
        check("rmb_a5_pd",   parallel_data, 8'hA5);
        check("rmb_a5_hdr",  a5_or_c3,  8'h01);
        check("rmb_a5_done", byte_done, 8'h01);
        check("rmb_a5_inpk", in_packet, 8'h01);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
